snake_collision_detector: RTL and testbench
===========================================

Name: snake_collision_detector

Overview:
- Combinational geometry checker with registered outputs for the FPGA Snake game.
- Each clock it tests the snake head against the apple, the four playfield border walls, and the snake's own body segments.
- Outputs: appleEaten, a per-cycle pulse/level, and collision, a sticky game-over flag cleared only by reset.
- Sits between the snake/apple position logic and the game-state controller.

Parameters:
- SegWidth, 10, snake segment width in pixels.
- SegHeight, 10, snake segment height in pixels.
- BorderThickness, 20, wall thickness in pixels on all four sides.
- DisplayWidth, 240, playfield width in pixels (X axis).
- DisplayHeight, 320, playfield height in pixels (Y axis).
- AppleWidth, 10, apple width in pixels.
- AppleHeight, 10, apple height in pixels.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- screenClock  in  1  display-domain clock; connected to clock at integration; no functional effect in this block.
- snakeLocX  in  1024  segment X top-left coords, 8 bits each; segment i at [8i+7:8i]; segment 0 is the head; max 128 segments.
- snakeLocY  in  1153  segment Y top-left coords, 9 bits each; segment i at [9i+8:9i]; bit 1152 unused.
- size  in  8  number of valid segments including the head.
- appleLocX  in  8  apple top-left X.
- appleLocY  in  9  apple top-left Y.
- appleEaten  out  1  head overlaps apple (registered).
- collision  out  1  sticky wall/self collision flag (registered).

Behaviour:
- Reset (async, active-high): appleEaten=0, collision=0; both held at 0 while reset is asserted.
- Let hx=snakeLocX[7:0] and hy=snakeLocY[8:0]. Do all arithmetic at ≥10 bits unsigned to avoid overflow.
- Overlap rule for rectangles A and B: Ax < Bx+Bw AND Bx < Ax+Aw AND Ay < By+Bh AND By < Ay+Ah. Edge-touching is not overlap; a 1-pixel overlap is overlap.
- Apple hit: overlap of head (SegWidth×SegHeight) with apple (AppleWidth×AppleHeight).
- Wall hit: any of
  - hx < BorderThickness
  - hy < BorderThickness
  - hx+SegWidth > DisplayWidth−BorderThickness
  - hy+SegHeight > DisplayHeight−BorderThickness
  - With defaults, the legal range is x 20..210 and y 20..290.
- Self hit: head overlaps segment i (SegWidth×SegHeight) for any i in 1..size−1.
  - Evaluate all 127 comparisons in parallel, each qualified by i < size.
  - size 0 or 1: no body checks.
  - size > 128 is treated as 128.
- Latency: one clock. Inputs are sampled at rising edge N; the result is visible after edge N.
- appleEaten <= apple hit, every cycle, not sticky. It drops the cycle after the apple moves away.
- collision <= collision OR wall hit OR self hit. Once set it stays 1 until reset, even if the head moves back into a legal area.
- Apple overlap does not affect collision. Wall/body hit does not affect appleEaten.
- Simultaneous apple hit and wall/body hit: both outputs assert in the same cycle.
- Reset asserted mid-collision clears collision immediately. Re-evaluation resumes on the first rising edge after deassertion.
- Inputs are assumed stable for a full clock period; no handshake.

Test Plan:
- Reset, then head (150,150), size=1, apple (0,20) -> appleEaten=0, collision=0.
- Head (30,30), segments (40,40),(50,50),(60,60), size=4, apple sequence:
  - apple (30,30), (25,25), (35,35), (35,25) -> appleEaten=1 each.
  - apple (70,70) between each hit -> appleEaten=0.
- Glance cases, head (30,30):
  - apple (21,30), (39,30), (30,21) -> appleEaten=1 (1-pixel overlap).
  - apple (20,30), (40,30), (30,20), (30,40) -> appleEaten=0 (edge touch).
- Walls, each followed by reset:
  - head (20,100) -> collision=0; then (19,100) -> collision=1.
  - head (100,20) -> 0; then (100,19) -> 1.
  - head (210,100) -> 0; then (211,100) -> 1.
  - head (100,290) -> 0; then (100,291) -> 1.
  - collision stays 1 across cycles until reset.
- Body: segments (100,100),(110,100),(120,100),(130,100), size=4 -> collision=0; head moved to (110,100) -> collision=1 one cycle later.
- Size gating: head equal to segment 3 position with size=3 -> collision=0; same stimulus with size=4 -> collision=1.

Source files
------------

// File: rtl/snake_collision_detector.sv
// Snake game collision detector: tests the head against the apple, the
// playfield walls and the body segments, registering the results.
// appleEaten follows the apple overlap every cycle; collision is sticky
// until reset.
module snake_collision_detector #(
    parameter int SegWidth        = 10,
    parameter int SegHeight       = 10,
    parameter int BorderThickness = 20,
    parameter int DisplayWidth    = 240,
    parameter int DisplayHeight   = 320,
    parameter int AppleWidth      = 10,
    parameter int AppleHeight     = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          screenClock,
    input  logic [1023:0] snakeLocX,
    input  logic [1152:0] snakeLocY,
    input  logic [7:0]    size,
    input  logic [7:0]    appleLocX,
    input  logic [8:0]    appleLocY,
    output logic          appleEaten,
    output logic          collision
);

    // All geometry is done at 11 bits so coordinate + extent never wraps.
    localparam logic [10:0] SEG_W     = 11'(SegWidth);
    localparam logic [10:0] SEG_H     = 11'(SegHeight);
    localparam logic [10:0] APPLE_W   = 11'(AppleWidth);
    localparam logic [10:0] APPLE_H   = 11'(AppleHeight);
    localparam logic [10:0] WALL_LO   = 11'(BorderThickness);
    localparam logic [10:0] WALL_X_HI = 11'(DisplayWidth - BorderThickness);
    localparam logic [10:0] WALL_Y_HI = 11'(DisplayHeight - BorderThickness);

    // Strict inequalities: rectangles that only share an edge do not overlap.
    function automatic logic rect_overlap(
        input logic [10:0] ax, input logic [10:0] ay,
        input logic [10:0] aw, input logic [10:0] ah,
        input logic [10:0] bx, input logic [10:0] by,
        input logic [10:0] bw, input logic [10:0] bh
    );
        return (ax < bx + bw) && (bx < ax + aw) &&
               (ay < by + bh) && (by < ay + ah);
    endfunction

    logic [10:0]  hx;
    logic [10:0]  hy;
    logic [10:0]  ax;
    logic [10:0]  ay;
    logic [7:0]   size_eff;
    logic [127:1] body_hit;
    logic         apple_hit;
    logic         wall_hit;
    logic         self_hit;
    logic         appleEaten_d;
    logic         appleEaten_q;
    logic         collision_d;
    logic         collision_q;

    // screenClock and the spare Y bit carry no function in this block.
    logic unused_inputs;
    assign unused_inputs = ^{screenClock, snakeLocY[1152]};

    assign hx = {3'b000, snakeLocX[7:0]};
    assign hy = {2'b00, snakeLocY[8:0]};
    assign ax = {3'b000, appleLocX};
    assign ay = {2'b00, appleLocY};

    // Only 128 segments exist; larger sizes behave as a full-length snake.
    assign size_eff = (size > 8'd128) ? 8'd128 : size;

    // One parallel head-vs-segment comparator per body slot, gated by size.
    genvar gi;
    generate
        for (gi = 1; gi < 128; gi++) begin : g_body
            localparam logic [7:0] IDX = 8'(gi);
            assign body_hit[gi] = (IDX < size_eff) &&
                rect_overlap(hx, hy, SEG_W, SEG_H,
                             {3'b000, snakeLocX[8*gi +: 8]},
                             {2'b00, snakeLocY[9*gi +: 9]},
                             SEG_W, SEG_H);
        end
    endgenerate

    assign apple_hit = rect_overlap(hx, hy, SEG_W, SEG_H, ax, ay, APPLE_W, APPLE_H);
    assign wall_hit  = (hx < WALL_LO) || (hy < WALL_LO) ||
                       (hx + SEG_W > WALL_X_HI) || (hy + SEG_H > WALL_Y_HI);
    assign self_hit  = |body_hit;

    // Next state: apple flag tracks the current overlap, collision accumulates.
    always_comb begin
        appleEaten_d = apple_hit;
        collision_d  = collision_q | wall_hit | self_hit;
    end

    // Output registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            appleEaten_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            appleEaten_q <= appleEaten_d;
            collision_q  <= collision_d;
        end
    end

    assign appleEaten = appleEaten_q;
    assign collision  = collision_q;

endmodule

// File: tb/tb_snake_collision_detector.sv
// Self-checking bench for snake_collision_detector: directed scenarios
// followed by randomized positions, checked against a geometric model.
module tb_snake_collision_detector;

    localparam int SW = 10, SH = 10, BT = 20, DW = 240, DH = 320, AW = 10, AH = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [1023:0] snakeLocX = '0;
    logic [1152:0] snakeLocY = '0;
    logic [7:0]    size = '0;
    logic [7:0]    appleLocX = '0;
    logic [8:0]    appleLocY = '0;
    logic          appleEaten;
    logic          collision;

    int sx [128];
    int sy [128];
    int nsize;
    int apx, apy;
    int exp_apple, exp_coll;
    int checks = 0;
    int errors = 0;

    snake_collision_detector dut (
        .clock      (clock),
        .reset      (reset),
        .screenClock(clock),
        .snakeLocX  (snakeLocX),
        .snakeLocY  (snakeLocY),
        .size       (size),
        .appleLocX  (appleLocX),
        .appleLocY  (appleLocY),
        .appleEaten (appleEaten),
        .collision  (collision)
    );

    always #5 clock = ~clock;

    function automatic bit ovl(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic bit model_apple();
        return ovl(sx[0], sy[0], SW, SH, apx, apy, AW, AH);
    endfunction

    function automatic bit model_hazard();
        int lim;
        bit hit;
        hit = (sx[0] < BT) || (sy[0] < BT) || (sx[0] + SW > DW - BT) || (sy[0] + SH > DH - BT);
        lim = (nsize > 128) ? 128 : nsize;
        for (int i = 1; i < lim; i++)
            if (ovl(sx[0], sy[0], SW, SH, sx[i], sy[i], SW, SH)) hit = 1'b1;
        return hit;
    endfunction

    task automatic check(string tag);
        checks++;
        assert (appleEaten === exp_apple[0]) else begin
            errors++;
            $error("FAIL %s appleEaten got %0b expected %0b", tag, appleEaten, exp_apple[0]);
        end
        checks++;
        assert (collision === exp_coll[0]) else begin
            errors++;
            $error("FAIL %s collision got %0b expected %0b", tag, collision, exp_coll[0]);
        end
    endtask

    // Drive the current arrays, clock once, update the model, compare.
    task automatic step(string tag);
        for (int i = 0; i < 128; i++) begin
            snakeLocX[8*i +: 8] = 8'(sx[i]);
            snakeLocY[9*i +: 9] = 9'(sy[i]);
        end
        snakeLocY[1152] = 1'($urandom);
        size      = 8'(nsize);
        appleLocX = 8'(apx);
        appleLocY = 9'(apy);
        @(posedge clock);
        exp_apple = int'(model_apple());
        exp_coll  = exp_coll | int'(model_hazard());
        #1;
        check(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic do_reset(string tag);
        reset = 1'b1;
        #2;
        exp_apple = 0;
        exp_coll  = 0;
        check(tag);
        reset = 1'b0;
    endtask

    task automatic clear_snake();
        for (int i = 0; i < 128; i++) begin
            sx[i] = 0;
            sy[i] = 0;
        end
    endtask

    task automatic set_head(int x, int y);
        sx[0] = x;
        sy[0] = y;
    endtask

    initial begin
        int ap [][2];
        int wl [][4];
        exp_apple = 0;
        exp_coll  = 0;
        clear_snake();
        apx = 0; apy = 20; nsize = 1;
        @(negedge clock);
        do_reset("reset_init");

        set_head(150, 150);
        step("idle_head");

        // Apple hits at several offsets, separated by misses.
        do_reset("reset_apple");
        set_head(30, 30);
        sx[1] = 40; sy[1] = 40; sx[2] = 50; sy[2] = 50; sx[3] = 60; sy[3] = 60;
        nsize = 4;
        ap = '{'{30,30}, '{25,25}, '{35,35}, '{35,25}};
        foreach (ap[k]) begin
            apx = ap[k][0]; apy = ap[k][1];
            step("apple_hit");
            apx = 70; apy = 70;
            step("apple_away");
        end

        // Glancing and edge-touching apples.
        ap = '{'{21,30}, '{39,30}, '{30,21}, '{20,30}, '{40,30}, '{30,20}, '{30,40}};
        foreach (ap[k]) begin
            apx = ap[k][0]; apy = ap[k][1];
            step("apple_glance");
        end

        // Walls: legal position then one pixel over, reset between.
        clear_snake();
        nsize = 1; apx = 0; apy = 0;
        wl = '{'{20,100,19,100}, '{100,20,100,19}, '{210,100,211,100}, '{100,290,100,291}};
        foreach (wl[k]) begin
            do_reset("reset_wall");
            set_head(wl[k][0], wl[k][1]);
            step("wall_legal");
            set_head(wl[k][2], wl[k][3]);
            step("wall_hit");
            set_head(150, 150);
            step("wall_sticky");
            step("wall_sticky2");
        end
        do_reset("reset_mid_collision");
        step("after_reset_legal");

        // Simultaneous apple and wall hit.
        set_head(19, 100); apx = 19; apy = 100;
        step("apple_and_wall");
        do_reset("reset_body");

        // Body collision.
        set_head(100, 100);
        sx[1] = 110; sy[1] = 100; sx[2] = 120; sy[2] = 100; sx[3] = 130; sy[3] = 100;
        nsize = 4; apx = 0; apy = 0;
        step("body_clear");
        set_head(110, 100);
        step("body_hit");
        do_reset("reset_gate");

        // Size gating on the last segment.
        clear_snake();
        set_head(150, 150);
        sx[1] = 100; sy[1] = 100; sx[2] = 120; sy[2] = 100; sx[3] = 150; sy[3] = 150;
        nsize = 3;
        step("gate_size3");
        nsize = 4;
        step("gate_size4");
        do_reset("reset_zero");
        nsize = 0;
        step("gate_size0");
        nsize = 200;
        sx[3] = 0; sy[3] = 0; sx[127] = 155; sy[127] = 145;
        step("gate_size200");

        // Randomized: head near the playfield, body clustered around it.
        for (int r = 0; r < 300; r++) begin
            if (r % 4 == 0) do_reset("rand_reset");
            sx[0] = $urandom_range(235, 10);
            sy[0] = $urandom_range(310, 10);
            for (int i = 1; i < 128; i++) begin
                if ($urandom_range(3, 0) == 0) begin
                    sx[i] = $urandom_range(255, 0);
                    sy[i] = $urandom_range(511, 0);
                end else begin
                    sx[i] = (sx[0] + 20 + $urandom_range(30, 0)) % 256;
                    sy[i] = (sy[0] + $urandom_range(40, 0) - 20 + 512) % 512;
                end
            end
            if ($urandom_range(5, 0) == 0) begin
                sx[$urandom_range(127, 1)] = sx[0] + 5 > 255 ? 255 : sx[0] + 5;
            end
            nsize = $urandom_range(255, 0);
            apx = (sx[0] + $urandom_range(24, 0) - 12 + 256) % 256;
            apy = (sy[0] + $urandom_range(24, 0) - 12 + 512) % 512;
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
